// File: rtl/nrad_seq_divider_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// State encodings are plain localparams so legacy code can compare against them directly.
package nrad_seq_divider_pkg;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StIdle = 3'd0;
    localparam logic [StateW-1:0] StIter = 3'd1;
    localparam logic [StateW-1:0] StCorr = 3'd2;
    localparam logic [StateW-1:0] StDz   = 3'd3;
    localparam logic [StateW-1:0] StDone = 3'd4;

endpackage

// File: rtl/nrad_step_row.sv
// One row of controlled add/subtract cells: sum_o = a_i + d_i (op_i=0) or a_i - d_i (op_i=1).
module nrad_step_row #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] d_i,
    input  logic         op_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] b;

    // Subtraction as two's complement: invert and inject op as carry-in.
    assign b = d_i ^ {W{op_i}};
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b} + {{W{1'b0}}, op_i};

endmodule

// File: rtl/nrad_seq_divider.sv
// Multi-cycle unsigned non-restoring divider: one add/subtract row per clock,
// followed by a single remainder-correction step.
module nrad_seq_divider
    import nrad_seq_divider_pkg::*;
#(
    parameter int unsigned XW = 4,
    parameter int unsigned YW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] X,
    input  logic [YW-1:0] Y,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] Q,
    output logic [YW-1:0] R,
    output logic          dz
);

    localparam int unsigned AW = YW + 2;
    localparam int unsigned CW = $clog2(XW + 1);

    logic [StateW-1:0] state_q, state_d;
    logic [AW-1:0]     a_q, d_q;
    logic [XW-1:0]     qs_q, q_q;
    logic [YW-1:0]     r_q;
    logic [CW-1:0]     cnt_q;
    logic              dz_q;

    logic [AW-1:0]     row_a, row_sum;
    logic              row_op, row_cout;

    always_comb begin
        row_a  = {a_q[AW-2:0], qs_q[XW-1]};
        row_op = ~a_q[AW-1];
        if (state_q == StCorr) begin
            row_a  = a_q;
            row_op = 1'b0;
        end
    end

    nrad_step_row #(
        .W (AW)
    ) u_row (
        .a_i    (row_a),
        .d_i    (d_q),
        .op_i   (row_op),
        .sum_o  (row_sum),
        .cout_o (row_cout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = (Y != '0) ? StIter : StDz;
            StIter: if (cnt_q == CW'(1)) state_d = StCorr;
            StCorr: state_d = StDone;
            StDz:   state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            d_q     <= '0;
            qs_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start && (Y != '0)) begin
                        a_q   <= '0;
                        qs_q  <= X;
                        d_q   <= {2'b00, Y};
                        cnt_q <= CW'(XW);
                        dz_q  <= 1'b0;
                    end
                end
                StIter: begin
                    // With |A| < 2D the carry out equals ~sign(new A), i.e. the quotient bit.
                    a_q   <= row_sum;
                    qs_q  <= {qs_q[XW-2:0], row_cout};
                    cnt_q <= cnt_q - CW'(1);
                end
                StCorr: begin
                    q_q  <= qs_q;
                    r_q  <= a_q[AW-1] ? row_sum[YW-1:0] : a_q[YW-1:0];
                    dz_q <= 1'b0;
                end
                StDz: begin
                    q_q  <= '1;
                    r_q  <= '0;
                    dz_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = ~ready;
    assign done  = (state_q == StDone);
    assign Q     = q_q;
    assign R     = r_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_nrad_seq_divider.sv
// Randomised and directed checks of nrad_seq_divider at (XW=4,YW=2) and (XW=8,YW=4)
// against a plain-arithmetic division model.
module tb_nrad_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start_a = 1'b0;
    logic [3:0] xa = '0;
    logic [1:0] ya = '0;
    logic       ready_a, busy_a, done_a, dz_a;
    logic [3:0] q_a;
    logic [1:0] r_a;

    logic       start_b = 1'b0;
    logic [7:0] xb = '0;
    logic [3:0] yb = '0;
    logic       ready_b, busy_b, done_b, dz_b;
    logic [7:0] q_b;
    logic [3:0] r_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nrad_seq_divider #(.XW(4), .YW(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_a),
        .X     (xa),
        .Y     (ya),
        .ready (ready_a),
        .busy  (busy_a),
        .done  (done_a),
        .Q     (q_a),
        .R     (r_a),
        .dz    (dz_a)
    );

    nrad_seq_divider #(.XW(8), .YW(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_b),
        .X     (xb),
        .Y     (yb),
        .ready (ready_b),
        .busy  (busy_b),
        .done  (done_b),
        .Q     (q_b),
        .R     (r_b),
        .dz    (dz_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: unsigned floor division; divide-by-zero yields all-ones quotient.
    task automatic model(input int xw, input int x, input int y,
                         output int q, output int r, output int z);
        if (y == 0) begin
            q = (1 << xw) - 1;
            r = 0;
            z = 1;
        end else begin
            q = x / y;
            r = x % y;
            z = 0;
        end
    endtask

    // Called #1 after a rising edge with the selected DUT idle.
    task automatic run_op(input int inst, input int x, input int y);
        int xw, eq, er, ez, n, got_q, got_r, got_z, got_rdy;
        bit seen;
        xw = (inst == 0) ? 4 : 8;
        model(xw, x, y, eq, er, ez);
        if (inst == 0) begin
            got_rdy = int'(ready_a);
            start_a = 1'b1; xa = x[3:0]; ya = y[1:0];
        end else begin
            got_rdy = int'(ready_b);
            start_b = 1'b1; xb = x[7:0]; yb = y[3:0];
        end
        check("ready_pre", got_rdy, 1);
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(posedge clk); #1;
            n++;
            seen = (inst == 0) ? done_a : done_b;
        end
        if (inst == 0) begin
            got_q = int'(q_a); got_r = int'(r_a); got_z = int'(dz_a);
        end else begin
            got_q = int'(q_b); got_r = int'(r_b); got_z = int'(dz_b);
        end
        check($sformatf("lat x=%0d y=%0d", x, y), n, (y == 0) ? 1 : xw + 1);
        check($sformatf("q x=%0d y=%0d", x, y), got_q, eq);
        check($sformatf("r x=%0d y=%0d", x, y), got_r, er);
        check($sformatf("dz x=%0d y=%0d", x, y), got_z, ez);
        @(posedge clk); #1;
        check("done_pulse", (inst == 0) ? int'(done_a) : int'(done_b), 0);
        check("ready_post", (inst == 0) ? int'(ready_a) : int'(ready_b), 1);
    endtask

    initial begin
        int pend_x[$];
        int pend_y[$];
        int last_q, last_r, accepts, dones, eq, er, ez, px, py, ndone;

        #3;
        check("rst_ready", ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_q", q_a, 0);
        check("rst_r", r_a, 0);
        check("rst_dz", dz_a, 0);
        check("rst_ready_b", ready_b, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 13, 3);
        run_op(0, 15, 1);
        run_op(0, 2, 3);
        run_op(0, 0, 2);
        run_op(0, 9, 0);
        run_op(0, 9, 2);

        // start held high with inputs churning while busy
        last_q = -1;
        last_r = -1;
        accepts = 0;
        dones = 0;
        start_a = 1'b1;
        for (int c = 0; c < 150; c++) begin
            xa = 4'($urandom);
            ya = 2'($urandom);
            if (ready_a) begin
                pend_x.push_back(int'(xa));
                pend_y.push_back(int'(ya));
                accepts++;
            end
            @(posedge clk); #1;
            if (done_a) begin
                dones++;
                if (pend_x.size() > 0) begin
                    px = pend_x.pop_front();
                    py = pend_y.pop_front();
                    model(4, px, py, eq, er, ez);
                    check("hold_q", q_a, eq);
                    check("hold_r", r_a, er);
                    check("hold_dz", dz_a, ez);
                end
                last_q = int'(q_a);
                last_r = int'(r_a);
            end else if (last_q >= 0) begin
                check("stable_q", q_a, last_q);
                check("stable_r", r_a, last_r);
            end
        end
        start_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done_a) begin
                dones++;
                if (pend_x.size() > 0) begin
                    px = pend_x.pop_front();
                    py = pend_y.pop_front();
                    model(4, px, py, eq, er, ez);
                    check("drain_q", q_a, eq);
                    check("drain_r", r_a, er);
                end
            end
        end
        check("hold_done_count", dones, accepts);
        check("hold_ready", ready_a, 1);

        // reset during the second iteration step
        start_a = 1'b1; xa = 4'd13; ya = 2'd3;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ready_a, 1);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_q", q_a, 0);
        check("mid_rst_r", r_a, 0);
        check("mid_rst_dz", dz_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done_a) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        run_op(0, 7, 2);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 4; y++) begin
                run_op(0, x, y);
            end
        end

        for (int i = 0; i < 60; i++) begin
            run_op(1, int'($urandom_range(0, 255)),
                   (i % 10 == 0) ? 0 : int'($urandom_range(1, 15)));
        end
        run_op(1, 255, 1);
        run_op(1, 255, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
